// File: rtl/alu_issue_ctrl_if.sv
// Handshake, operand and ALU-strobe bundle between alu_issue_ctrl and its environment.
// slave = the issue controller, master = the requester/ALU/writeback side.
interface alu_issue_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  opcode;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_add, alu_sub, alu_mul, alu_div, alu_shr, alu_shra, alu_shl;
  logic        alu_ror, alu_rol, alu_and, alu_or, alu_neg, alu_not;
  logic [63:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        res_div0;
  logic        err_illegal;

  modport slave (
    input  op_valid, opcode, src_a, src_b, alu_out, res_ready,
    output op_ready, alu_a, alu_b, alu_add, alu_sub, alu_mul, alu_div, alu_shr, alu_shra,
           alu_shl, alu_ror, alu_rol, alu_and, alu_or, alu_neg, alu_not,
           res_valid, z_hi, z_lo, res_div0, err_illegal
  );

  modport master (
    output op_valid, opcode, src_a, src_b, alu_out, res_ready,
    input  op_ready, alu_a, alu_b, alu_add, alu_sub, alu_mul, alu_div, alu_shr, alu_shra,
           alu_shl, alu_ror, alu_rol, alu_and, alu_or, alu_neg, alu_not,
           res_valid, z_hi, z_lo, res_div0, err_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for the Mini SRC ALU: decode, strobe, wait, capture into Z.
// Optional divide-by-zero trap enabled by defining ALU_DIV0_TRAP_EN.
module alu_issue_ctrl #(
  parameter int unsigned MULDIV_WAIT = 4,
  parameter int unsigned SIMPLE_WAIT = 1
) (
  input  logic          clock,
  input  logic          clear,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  // Strobe vector bit positions
  localparam int unsigned SAdd = 0, SSub = 1, SMul = 2, SDiv = 3, SShr = 4, SShra = 5;
  localparam int unsigned SShl = 6, SRor = 7, SRol = 8, SAnd = 9, SOr = 10, SNeg = 11;
  localparam int unsigned SNot = 12;

  localparam logic [3:0] MulDivCnt = 4'(MULDIV_WAIT);
  localparam logic [3:0] SimpleCnt = 4'(SIMPLE_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [12:0] strobe_q, strobe_d;
  logic        res_valid_q, res_valid_d;
  logic        err_q, err_d;
  logic        div0_q, div0_d;
  logic        trap_q, trap_d;

  logic [12:0] dec_strobe;
  logic        legal;
  logic        is_muldiv;
  logic        trap_hit;

  always_comb begin
    dec_strobe = '0;
    legal      = 1'b1;
    case (bus.opcode)
      5'b00011, 5'b01100: dec_strobe[SAdd]  = 1'b1;
      5'b00100:           dec_strobe[SSub]  = 1'b1;
      5'b00101, 5'b01101: dec_strobe[SAnd]  = 1'b1;
      5'b00110, 5'b01110: dec_strobe[SOr]   = 1'b1;
      5'b00111:           dec_strobe[SShr]  = 1'b1;
      5'b01000:           dec_strobe[SShra] = 1'b1;
      5'b01001:           dec_strobe[SShl]  = 1'b1;
      5'b01010:           dec_strobe[SRor]  = 1'b1;
      5'b01011:           dec_strobe[SRol]  = 1'b1;
      5'b01111:           dec_strobe[SMul]  = 1'b1;
      5'b10000:           dec_strobe[SDiv]  = 1'b1;
      5'b10001:           dec_strobe[SNeg]  = 1'b1;
      5'b10010:           dec_strobe[SNot]  = 1'b1;
      default:            legal             = 1'b0;
    endcase
  end

  assign is_muldiv = dec_strobe[SMul] | dec_strobe[SDiv];

`ifdef ALU_DIV0_TRAP_EN
  assign trap_hit = dec_strobe[SDiv] && (bus.src_b == 32'd0);
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    zhi_d       = zhi_q;
    zlo_d       = zlo_q;
    strobe_d    = strobe_q;
    res_valid_d = res_valid_q;
    err_d       = 1'b0;
    div0_d      = div0_q;
    trap_d      = trap_q;
    unique case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          if (legal) begin
            a_d      = bus.src_a;
            b_d      = bus.src_b;
            // A trapped divide runs the full wait with the ALU left idle
            strobe_d = trap_hit ? '0 : dec_strobe;
            trap_d   = trap_hit;
            cnt_d    = is_muldiv ? MulDivCnt : SimpleCnt;
            state_d  = StExec;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StExec: begin
        if (cnt_q == 4'd1) begin
          if (trap_q) begin
            zhi_d = a_q;
            zlo_d = 32'hFFFF_FFFF;
          end else begin
            zhi_d = bus.alu_out[63:32];
            zlo_d = bus.alu_out[31:0];
          end
          div0_d      = trap_q;
          strobe_d    = '0;
          res_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          div0_d      = 1'b0;
          trap_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      zhi_q       <= '0;
      zlo_q       <= '0;
      strobe_q    <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      div0_q      <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      zhi_q       <= zhi_d;
      zlo_q       <= zlo_d;
      strobe_q    <= strobe_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      div0_q      <= div0_d;
      trap_q      <= trap_d;
    end
  end

  assign bus.op_ready    = (state_q == StIdle) && !clear;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.z_hi        = zhi_q;
  assign bus.z_lo        = zlo_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_div0    = div0_q;
  assign bus.err_illegal = err_q;
  assign bus.alu_add     = strobe_q[SAdd];
  assign bus.alu_sub     = strobe_q[SSub];
  assign bus.alu_mul     = strobe_q[SMul];
  assign bus.alu_div     = strobe_q[SDiv];
  assign bus.alu_shr     = strobe_q[SShr];
  assign bus.alu_shra    = strobe_q[SShra];
  assign bus.alu_shl     = strobe_q[SShl];
  assign bus.alu_ror     = strobe_q[SRor];
  assign bus.alu_rol     = strobe_q[SRol];
  assign bus.alu_and     = strobe_q[SAnd];
  assign bus.alu_or      = strobe_q[SOr];
  assign bus.alu_neg     = strobe_q[SNeg];
  assign bus.alu_not     = strobe_q[SNot];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, opcode-level reference model,
// directed scenarios plus randomized traffic.
module tb_alu_issue_ctrl;
  localparam int MulDivWait = 4;
  localparam int SimpleWait = 1;

  logic clock = 1'b0;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .MULDIV_WAIT(MulDivWait),
    .SIMPLE_WAIT(SimpleWait)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Op index: 0 add,1 sub,2 mul,3 div,4 shr,5 shra,6 shl,7 ror,8 rol,9 and,10 or,11 neg,12 not
  logic [12:0] stb;
  assign stb = {bus.alu_not, bus.alu_neg, bus.alu_or, bus.alu_and, bus.alu_rol, bus.alu_ror,
                bus.alu_shl, bus.alu_shra, bus.alu_shr, bus.alu_div, bus.alu_mul, bus.alu_sub,
                bus.alu_add};

  function automatic logic [63:0] alu_calc(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] p;
    logic [4:0]  s;
    s = b[4:0];
    r = 32'd0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      3: begin
        if (b == 32'd0) return 64'd0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      4:  r = a >> s;
      5:  r = $signed(a) >>> s;
      6:  r = a << s;
      7:  r = (a >> s) | (a << (6'd32 - {1'b0, s}));
      8:  r = (a << s) | (a >> (6'd32 - {1'b0, s}));
      9:  r = a & b;
      10: r = a | b;
      11: r = -b;
      12: r = ~b;
      default: return 64'd0;
    endcase
    return {a ^ b, r};
  endfunction

  function automatic int op_of(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b01100: return 0;
      5'b00100: return 1;
      5'b01111: return 2;
      5'b10000: return 3;
      5'b00111: return 4;
      5'b01000: return 5;
      5'b01001: return 6;
      5'b01010: return 7;
      5'b01011: return 8;
      5'b00101, 5'b01101: return 9;
      5'b00110, 5'b01110: return 10;
      5'b10001: return 11;
      5'b10010: return 12;
      default: return -1;
    endcase
  endfunction

  // Environment ALU, driven by whichever single strobe is high
  always_comb begin
    int op;
    op = -1;
    if ($countones(stb) == 1)
      for (int i = 0; i < 13; i++) if (stb[i]) op = i;
    bus.alu_out = alu_calc(op, bus.alu_a, bus.alu_b);
  end

  // Drives one transaction and measures it; comparisons live in the callers.
  task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output int lat, output int stb_cyc, output int stb_bad,
                       output logic [12:0] seen, output logic [31:0] zh, output logic [31:0] zl,
                       output logic d0, output int unstable, output logic rdy_after);
    lat = -1; stb_cyc = 0; stb_bad = 0; seen = '0; zh = '0; zl = '0; d0 = 1'b0;
    unstable = 0; rdy_after = 1'b0;
    @(negedge clock);
    bus.op_valid = 1'b1; bus.opcode = opc; bus.src_a = a; bus.src_b = b; bus.res_ready = 1'b0;
    @(negedge clock);
    bus.op_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      if (bus.res_valid) begin
        lat = k;
        break;
      end
      if (stb != '0) stb_cyc++;
      if ($countones(stb) > 1) stb_bad++;
      seen |= stb;
    end
    if (lat < 0) return;
    zh = bus.z_hi; zl = bus.z_lo; d0 = bus.res_div0;
    if (stb != '0) stb_bad++;
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      if (bus.z_hi !== zh || bus.z_lo !== zl || bus.res_valid !== 1'b1 || bus.op_ready !== 1'b0
          || stb !== '0 || bus.res_div0 !== d0 || bus.alu_a !== a || bus.alu_b !== b)
        unstable++;
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    rdy_after = bus.op_ready && !bus.res_valid && !bus.res_div0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if ({bus.op_ready, bus.res_valid, bus.res_div0, bus.err_illegal, stb} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b d0=%b err=%b stb=%h, want all 0",
               bus.op_ready, bus.res_valid, bus.res_div0, bus.err_illegal, stb);
    end
    tests++;
    if ({bus.alu_a, bus.alu_b, bus.z_hi, bus.z_lo} !== 128'd0) begin
      fails++;
      $display("FAIL reset_data: got a=%h b=%h zh=%h zl=%h, want 0",
               bus.alu_a, bus.alu_b, bus.z_hi, bus.z_lo);
    end
    clear = 1'b0;
    #1;
    tests++;
    if (bus.op_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", bus.op_ready);
    end
  endtask

  task automatic test_add();
    int lat, sc, sb, us; logic [12:0] seen; logic [31:0] zh, zl; logic d0, ra;
    issue(5'b00011, 32'd5, 32'd7, 0, lat, sc, sb, seen, zh, zl, d0, us, ra);
    tests++;
    if (lat !== SimpleWait || sc !== SimpleWait || seen !== 13'h1 || sb !== 0) begin
      fails++;
      $display("FAIL add_timing: got lat=%0d strobe_cycles=%0d seen=%h bad=%0d, want %0d %0d 0001 0",
               lat, sc, seen, sb, SimpleWait, SimpleWait);
    end
    tests++;
    if (zl !== 32'd12 || zh !== (32'd5 ^ 32'd7) || ra !== 1'b1) begin
      fails++;
      $display("FAIL add_result: got zl=%0d zh=%h rdy_after=%b, want 12 %h 1", zl, zh, ra,
               32'd5 ^ 32'd7);
    end
  endtask

  task automatic test_mul();
    int lat, sc, sb, us; logic [12:0] seen; logic [31:0] zh, zl; logic d0, ra;
    issue(5'b01111, 32'h0001_0000, 32'h0001_0000, 0, lat, sc, sb, seen, zh, zl, d0, us, ra);
    tests++;
    if (lat !== MulDivWait || sc !== MulDivWait || seen !== 13'h4 || sb !== 0) begin
      fails++;
      $display("FAIL mul_timing: got lat=%0d strobe_cycles=%0d seen=%h bad=%0d, want %0d %0d 0004 0",
               lat, sc, seen, sb, MulDivWait, MulDivWait);
    end
    tests++;
    if (zh !== 32'd1 || zl !== 32'd0) begin
      fails++;
      $display("FAIL mul_result: got zh=%h zl=%h, want 1 0", zh, zl);
    end
  endtask

  task automatic test_div_stall();
    int lat, sc, sb, us; logic [12:0] seen; logic [31:0] zh, zl; logic d0, ra;
    issue(5'b10000, 32'd17, 32'd5, 3, lat, sc, sb, seen, zh, zl, d0, us, ra);
    tests++;
    if (zh !== 32'd2 || zl !== 32'd3 || lat !== MulDivWait || seen !== 13'h8) begin
      fails++;
      $display("FAIL div_result: got zh=%0d zl=%0d lat=%0d seen=%h, want 2 3 %0d 0008",
               zh, zl, lat, seen, MulDivWait);
    end
    tests++;
    if (us !== 0 || ra !== 1'b1) begin
      fails++;
      $display("FAIL div_hold: got unstable=%0d rdy_after=%b, want 0 1", us, ra);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] codes [2];
    codes[0] = 5'b00000; codes[1] = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bus.op_valid = 1'b1; bus.opcode = codes[i]; bus.src_a = $urandom; bus.src_b = $urandom;
      @(negedge clock);
      bus.op_valid = 1'b0;
      tests++;
      if (bus.err_illegal !== 1'b1 || stb !== '0 || bus.res_valid !== 1'b0
          || bus.op_ready !== 1'b1) begin
        fails++;
        $display("FAIL illegal_pulse op=%b: got err=%b stb=%h rv=%b rdy=%b, want 1 0 0 1",
                 codes[i], bus.err_illegal, stb, bus.res_valid, bus.op_ready);
      end
      @(negedge clock);
      tests++;
      if (bus.err_illegal !== 1'b0 || bus.res_valid !== 1'b0 || stb !== '0) begin
        fails++;
        $display("FAIL illegal_after op=%b: got err=%b rv=%b stb=%h, want 0 0 0",
                 codes[i], bus.err_illegal, bus.res_valid, stb);
      end
    end
  endtask

  task automatic test_div0();
    int lat, sc, sb, us; logic [12:0] seen; logic [31:0] zh, zl; logic d0, ra;
    logic [31:0] ezh, ezl; logic ed0; logic [12:0] eseen;
`ifdef ALU_DIV0_TRAP_EN
    ezh = 32'd9; ezl = 32'hFFFF_FFFF; ed0 = 1'b1; eseen = 13'h0;
`else
    ezh = 32'd0; ezl = 32'd0; ed0 = 1'b0; eseen = 13'h8;
`endif
    issue(5'b10000, 32'd9, 32'd0, 2, lat, sc, sb, seen, zh, zl, d0, us, ra);
    tests++;
    if (zh !== ezh || zl !== ezl || d0 !== ed0 || seen !== eseen || lat !== MulDivWait) begin
      fails++;
      $display("FAIL div0: got zh=%h zl=%h d0=%b seen=%h lat=%0d, want %h %h %b %h %0d",
               zh, zl, d0, seen, lat, ezh, ezl, ed0, eseen, MulDivWait);
    end
    tests++;
    if (us !== 0 || ra !== 1'b1) begin
      fails++;
      $display("FAIL div0_hold: got unstable=%0d rdy_after=%b, want 0 1", us, ra);
    end
  endtask

  task automatic test_clear();
    int late;
    @(negedge clock);
    bus.op_valid = 1'b1; bus.opcode = 5'b01111; bus.src_a = 32'd3; bus.src_b = 32'd4;
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.op_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (bus.alu_mul !== 1'b1) begin
      fails++;
      $display("FAIL clear_pre_mul: got alu_mul=%b want 1", bus.alu_mul);
    end
    clear = 1'b1;
    #1;
    tests++;
    if (stb !== '0 || bus.res_valid !== 1'b0 || bus.op_ready !== 1'b0
        || {bus.alu_a, bus.alu_b, bus.z_hi, bus.z_lo} !== 128'd0) begin
      fails++;
      $display("FAIL clear_immediate: got stb=%h rv=%b rdy=%b a=%h b=%h zh=%h zl=%h, want 0",
               stb, bus.res_valid, bus.op_ready, bus.alu_a, bus.alu_b, bus.z_hi, bus.z_lo);
    end
    @(negedge clock);
    clear = 1'b0;
    #1;
    tests++;
    if (bus.op_ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_release_ready: got %b want 1", bus.op_ready);
    end
    late = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.res_valid !== 1'b0 || stb !== '0) late++;
    end
    bus.res_ready = 1'b0;
    tests++;
    if (late !== 0) begin
      fails++;
      $display("FAIL clear_no_result: got %0d active cycles want 0", late);
    end
  endtask

  task automatic test_random();
    logic [4:0] legal [17];
    legal = '{5'b00011, 5'b01100, 5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b01110, 5'b00111,
              5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010,
              5'b01111};
    for (int n = 0; n < 30; n++) begin
      int lat, sc, sb, us, op, wait_n; logic [12:0] seen; logic [31:0] zh, zl, a, b;
      logic d0, ra; logic [63:0] exp; logic [4:0] opc;
      opc = legal[$urandom_range(0, 16)];
      op  = op_of(opc);
      a   = $urandom;
      b   = (op == 3) ? 32'($urandom_range(1, 5000)) : $urandom;
      exp = alu_calc(op, a, b);
      wait_n = (op == 2 || op == 3) ? MulDivWait : SimpleWait;
      issue(opc, a, b, int'($urandom_range(0, 3)), lat, sc, sb, seen, zh, zl, d0, us, ra);
      tests++;
      if ({zh, zl} !== exp || d0 !== 1'b0) begin
        fails++;
        $display("FAIL rand_result op=%b a=%h b=%h: got %h_%h d0=%b, want %h d0=0",
                 opc, a, b, zh, zl, d0, exp);
      end
      tests++;
      if (lat !== wait_n || sc !== wait_n || sb !== 0 || seen !== (13'd1 << op)
          || us !== 0 || ra !== 1'b1) begin
        fails++;
        $display("FAIL rand_ctrl op=%b: got lat=%0d sc=%0d bad=%0d seen=%h us=%0d ra=%b, want lat=sc=%0d seen=%h",
                 opc, lat, sc, sb, seen, us, ra, wait_n, 13'd1 << op);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [4:0] opc, input int n);
    int acc[$];
    int cyc;
    cyc = 0;
    @(negedge clock);
    bus.op_valid = 1'b1; bus.opcode = opc; bus.src_a = $urandom;
    bus.src_b = 32'($urandom_range(1, 100)); bus.res_ready = 1'b1;
    while (acc.size() < 3 && cyc < 80) begin
      if (bus.op_valid && bus.op_ready) acc.push_back(cyc);
      @(negedge clock);
      cyc++;
    end
    bus.op_valid = 1'b0;
    for (int k = 0; k < 40 && !bus.op_ready; k++) @(negedge clock);
    bus.res_ready = 1'b0;
    tests++;
    if (acc.size() != 3) begin
      fails++;
      $display("FAIL b2b_count op=%b: got %0d accepts want 3", opc, acc.size());
    end else begin
      tests++;
      if (acc[1] - acc[0] != n + 2 || acc[2] - acc[1] != n + 2) begin
        fails++;
        $display("FAIL b2b_period op=%b: got %0d,%0d want %0d", opc, acc[1] - acc[0],
                 acc[2] - acc[1], n + 2);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    bus.op_valid = 1'b0; bus.opcode = '0; bus.src_a = '0; bus.src_b = '0; bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div_stall();
    test_illegal();
    test_div0();
    test_clear();
    test_random();
    test_back_to_back(5'b00011, SimpleWait);
    test_back_to_back(5'b01111, MulDivWait);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/capture controller wrapped around the 32-bit ALU in the Mini SRC datapath. It accepts one decoded arithmetic/logic operation with two 32-bit operands over a valid/ready handshake. It drives the ALU's operand inputs and one-hot operation strobes, waits a fixed settle time (longer for MUL/DIV), then captures the 64-bit ALU result into the Z register pair. Z is presented to the writeback side (HI/LO or general register file) over a second valid/ready handshake.

## Interface
- `MULDIV_WAIT`, 4: EXEC cycles for MUL/DIV, range 1–15.
- `SIMPLE_WAIT`, 1: EXEC cycles for all other ops, range 1–15.

- `clock` in 1: sole clock, rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `op_valid` in 1: operation offered.
- `op_ready` out 1: block can accept.
- `opcode` in 5: Mini SRC opcode field.
- `src_a`, `src_b` in 32 each: operands.
- `alu_a`, `alu_b` out 32 each: registered ALU operands.
- `alu_add`, `alu_sub`, `alu_mul`, `alu_div`, `alu_shr`, `alu_shra`, `alu_shl`, `alu_ror`, `alu_rol`, `alu_and`, `alu_or`, `alu_neg`, `alu_not` out 1 each: registered one-hot ALU strobes.
- `alu_out` in 64: ALU result, combinational from `alu_a`/`alu_b`/strobes.
- `res_valid` out 1: Z holds a result.
- `res_ready` in 1: consumer takes the result.
- `z_hi`, `z_lo` out 32 each: captured `alu_out[63:32]` and `alu_out[31:0]`.
- `res_div0` out 1: result is a divide-by-zero substitute.
- `err_illegal` out 1: one-cycle pulse on an accepted non-ALU opcode.

## Operation
- Opcode map:
  - 00011 and 01100 → ADD
  - 00100 → SUB
  - 00101 and 01101 → AND
  - 00110 and 01110 → OR
  - 00111 → SHR, 01000 → SHRA, 01001 → SHL, 01010 → ROR, 01011 → ROL
  - 01111 → MUL, 10000 → DIV, 10001 → NEG, 10010 → NOT
  - Every other value is illegal.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - `op_ready`=1.
  - On `op_valid`&`op_ready` with a legal opcode: register `src_a`/`src_b` into `alu_a`/`alu_b`, assert exactly one strobe, load the wait counter with `MULDIV_WAIT` (MUL/DIV) or `SIMPLE_WAIT` (others), go to EXEC.
  - On an illegal opcode: consume it, pulse `err_illegal` the next cycle, stay IDLE, no strobe.
- EXEC:
  - `op_ready`=0. The counter decrements each cycle.
  - On the edge where the counter equals 1: capture `alu_out` into `z_hi`/`z_lo`, drop all strobes, set `res_valid`, go to HOLD.
- HOLD:
  - `z_hi`/`z_lo`/`res_valid` stay stable. `alu_a`/`alu_b` hold their values. Strobes stay low.
  - On `res_valid`&`res_ready`: clear `res_valid`, go to IDLE.
- Exactly one strobe is ever high, and only in EXEC.
- Logic and shift results: `z_hi` is whatever the ALU drives on `[63:32]`, captured unmodified. DIV: `z_hi`=remainder, `z_lo`=quotient. MUL: full 64-bit product.
- `clear` at any point, including mid-EXEC or HOLD:
  - Immediately returns the FSM to IDLE and discards any in-flight result.
  - Forces all strobes, `res_valid`, `res_div0` and `err_illegal` to 0; `alu_a`/`alu_b`/`z_hi`/`z_lo` to 0; counter to 0.
  - `op_ready` is 0 while `clear` is high and 1 on the first cycle after release.

## Timing
- Operation accepted at edge T0 → strobes high from T0 until edge T0+N, where N is the selected wait.
- `res_valid` is high from T0+N onward. Latency is N edges.
- Result handed off at edge T1 → `op_ready`=1 from T1. The next accept occurs at the earliest at edge T1+1.
- Back-to-back throughput: N+2 cycles per operation when `res_ready` is held high.
- `op_ready` is combinational from state only, never from `op_valid`. `res_valid` is registered.

## Configuration
- `ALU_DIV0_TRAP_EN` defined:
  - DIV with `src_b`==0 asserts no strobe.
  - EXEC still lasts `MULDIV_WAIT` cycles.
  - Capture forces `z_hi`=`src_a` (remainder) and `z_lo`=32'hFFFF_FFFF, with `res_div0`=1 for the duration of that HOLD.
- Not defined: divide-by-zero is issued like any other DIV, `alu_out` is captured as-is, and `res_div0` is tied 0.

## Test plan
- ADD 5 + 7 (opcode 00011), `SIMPLE_WAIT`=1: `alu_add` high one cycle; `res_valid` at T0+1; `z_lo`=12.
- MUL 0x0001_0000 × 0x0001_0000, `MULDIV_WAIT`=4: `alu_mul` high exactly 4 cycles; `z_hi`=1, `z_lo`=0 at T0+4.
- DIV 17 / 5 with `res_ready` low for 3 cycles: `z_hi`=2, `z_lo`=3 held stable; `op_ready`=0 throughout; IDLE one edge after `res_ready` rises.
- Opcode 00000 offered: accepted, `err_illegal` one-cycle pulse, no strobe, `res_valid` stays 0.
- DIV 9 / 0 with `ALU_DIV0_TRAP_EN`: `z_hi`=9, `z_lo`=0xFFFF_FFFF, `res_div0`=1, `alu_div` never high.
- `clear` pulsed two cycles into a MUL: strobes and `res_valid` drop immediately, outputs 0, `op_ready`=1 the cycle after release, no result ever emitted.
